// File: rtl/mul_seq_pkg.sv
// Shared encodings and helpers for the sequential multiplier.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        MODE_MUL     = 2'b00,
        MODE_UMULL   = 2'b01,
        MODE_SMULL   = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } state_e;

    function automatic int iter_count(input int width, input int bpc);
        return width / bpc;
    endfunction

endpackage

// File: rtl/mul_seq_unit_if.sv
// Request/result bundle between the datapath controller and the multiplier.
interface mul_seq_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic [1:0]       flags_nz;
    logic             err;

    modport master (
        output start, mode, op_a, op_b,
        input  busy, done, res_lo, res_hi, flags_nz, err
    );

    modport slave (
        input  start, mode, op_a, op_b,
        output busy, done, res_lo, res_hi, flags_nz, err
    );
endinterface

// File: rtl/mul_step.sv
// One shift-add step: adds multiplicand * BPC multiplier bits into the high
// accumulator half, returning the new high half and the carry-out bits.
module mul_step #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] mcand,
    input  logic [BPC-1:0]   bits,
    output logic [WIDTH-1:0] sum,
    output logic [BPC-1:0]   carry
);
    logic [WIDTH+BPC-1:0] partial;
    logic [WIDTH+BPC-1:0] total;

    always_comb begin
        partial        = {{BPC{1'b0}}, mcand} * {{WIDTH{1'b0}}, bits};
        total          = {{BPC{1'b0}}, acc_hi} + partial;
        {carry, sum}   = total;
    end
endmodule

// File: rtl/mul_seq_unit.sv
// Multicycle MUL/UMULL/SMULL unit: magnitude shift-add over WIDTH/BPC cycles,
// with sign fix-up and N/Z flag generation in a final cycle.
module mul_seq_unit
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input logic           clk,
    input logic           reset,
    mul_seq_unit_if.slave bus
);
    localparam int ITERS = iter_count(WIDTH, BPC);
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    state_e             state, state_n;
    mode_e              mode_q;
    logic [WIDTH-1:0]   mcand, mplier, a_abs, b_abs;
    logic [WIDTH-1:0]   res_lo_q, res_hi_q;
    logic [2*WIDTH-1:0] acc, acc_next, fixed;
    logic [CNT_W-1:0]   cnt;
    logic               sign_q, err_q;
    logic [1:0]         flags_q;
    logic               accept, illegal, busy, done;
    logic               n_flag, z_flag;
    logic [WIDTH-1:0]   step_sum;
    logic [BPC-1:0]     step_carry;

    mul_step #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
        .acc_hi (acc[2*WIDTH-1:WIDTH]),
        .mcand  (mcand),
        .bits   (mplier[BPC-1:0]),
        .sum    (step_sum),
        .carry  (step_carry)
    );

    // The carry becomes the top bits after the right shift; the lowest BPC
    // accumulator bits fall off.
    assign acc_next = {step_carry, step_sum, acc[WIDTH-1:BPC]};
    assign illegal  = (mode_e'(bus.mode) == MODE_ILLEGAL);
    assign a_abs    = mcand[WIDTH-1]  ? ('0 - mcand)  : mcand;
    assign b_abs    = mplier[WIDTH-1] ? ('0 - mplier) : mplier;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_n = illegal ? ST_DONE : ST_PREP;
                end
            end
            ST_PREP: begin
                busy    = 1'b1;
                state_n = ST_ITER;
            end
            ST_ITER: begin
                busy = 1'b1;
                if (cnt == '0) state_n = ST_FIX;
            end
            ST_FIX: begin
                busy    = 1'b1;
                state_n = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        fixed = sign_q ? ('0 - acc) : acc;
        if (mode_q == MODE_MUL) begin
            n_flag = fixed[WIDTH-1];
            z_flag = (fixed[WIDTH-1:0] == '0);
        end else begin
            n_flag = fixed[2*WIDTH-1];
            z_flag = (fixed == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= MODE_MUL;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            err_q    <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mcand  <= bus.op_a;
                        mplier <= bus.op_b;
                        mode_q <= mode_e'(bus.mode);
                        err_q  <= illegal;
                        if (illegal) begin
                            res_lo_q <= '0;
                            res_hi_q <= '0;
                            flags_q  <= '0;
                        end
                    end
                end
                ST_PREP: begin
                    if (mode_q == MODE_SMULL) begin
                        mcand  <= a_abs;
                        mplier <= b_abs;
                        sign_q <= mcand[WIDTH-1] ^ mplier[WIDTH-1];
                    end else begin
                        sign_q <= 1'b0;
                    end
                    acc <= '0;
                    cnt <= CNT_W'(ITERS - 1);
                end
                ST_ITER: begin
                    acc    <= acc_next;
                    mplier <= mplier >> BPC;
                    cnt    <= cnt - CNT_W'(1);
                end
                ST_FIX: begin
                    res_lo_q <= fixed[WIDTH-1:0];
                    res_hi_q <= (mode_q == MODE_MUL) ? '0 : fixed[2*WIDTH-1:WIDTH];
                    flags_q  <= {n_flag, z_flag};
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.err      = done & err_q;
    assign bus.res_lo   = res_lo_q;
    assign bus.res_hi   = res_hi_q;
    assign bus.flags_nz = flags_q;
endmodule

// File: tb/tb_mul_seq_unit.sv
// Bench for mul_seq_unit: directed vector table, protocol sequences and
// randomized operations against a plain-arithmetic product model.
module tb_mul_seq_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_seq_unit_if #(.WIDTH(32)) bus1 ();
    mul_seq_unit_if #(.WIDTH(32)) bus4 ();

    mul_seq_unit #(.WIDTH(32), .BPC(1)) dut1 (.clk(clk), .reset(rst), .bus(bus1));
    mul_seq_unit #(.WIDTH(32), .BPC(4)) dut4 (.clk(clk), .reset(rst), .bus(bus4));

    logic        sel;
    logic        t_start;
    logic [1:0]  t_mode;
    logic [31:0] t_a, t_b;

    assign bus1.start = t_start & ~sel;
    assign bus1.mode  = t_mode;
    assign bus1.op_a  = t_a;
    assign bus1.op_b  = t_b;
    assign bus4.start = t_start & sel;
    assign bus4.mode  = t_mode;
    assign bus4.op_a  = t_a;
    assign bus4.op_b  = t_b;

    logic        o_busy, o_done, o_err;
    logic [31:0] o_lo, o_hi;
    logic [1:0]  o_nz;

    always_comb begin
        if (sel) begin
            o_busy = bus4.busy; o_done = bus4.done; o_err = bus4.err;
            o_lo = bus4.res_lo; o_hi = bus4.res_hi; o_nz = bus4.flags_nz;
        end else begin
            o_busy = bus1.busy; o_done = bus1.done; o_err = bus1.err;
            o_lo = bus1.res_lo; o_hi = bus1.res_hi; o_nz = bus1.flags_nz;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: architectural product from plain 64-bit arithmetic.
    task automatic model(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi,
                         output logic [1:0] nz, output logic er);
        logic [63:0] r;
        longint      p;
        lo = '0; hi = '0; nz = '0; er = 1'b0;
        case (m)
            2'b00: begin
                lo = a * b;
                nz = {lo[31], lo == 32'd0};
            end
            2'b01, 2'b10: begin
                if (m == 2'b01) r = {32'd0, a} * {32'd0, b};
                else begin
                    p = longint'($signed(a)) * longint'($signed(b));
                    r = 64'(p);
                end
                lo = r[31:0];
                hi = r[63:32];
                nz = {r[63], r == 64'd0};
            end
            default: er = 1'b1;
        endcase
    endtask

    // Starts one operation and waits for done; cycle 1 is the cycle after the
    // accepting edge. poke > 0 pulses a second start at that cycle.
    task automatic do_op(input logic s, input logic [1:0] m, input logic [31:0] a,
                         input logic [31:0] b, input int poke,
                         output int lat, output int bcyc,
                         output logic [31:0] lo, output logic [31:0] hi,
                         output logic [1:0] nz, output logic er, output logic got);
        @(negedge clk);
        sel = s; t_start = 1'b1; t_mode = m; t_a = a; t_b = b;
        @(negedge clk);
        t_start = 1'b0;
        t_mode = 2'($urandom_range(0, 3)); t_a = $urandom; t_b = $urandom;
        got = 1'b0; lat = 0; bcyc = 0; lo = '0; hi = '0; nz = '0; er = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (c == poke) begin
                t_start = 1'b1; t_mode = 2'b01; t_a = $urandom; t_b = $urandom;
            end else if (c == poke + 1) begin
                t_start = 1'b0;
            end
            if (o_busy) bcyc++;
            if (o_done) begin
                got = 1'b1; lat = c; lo = o_lo; hi = o_hi; nz = o_nz; er = o_err;
                break;
            end
            @(negedge clk);
        end
        t_start = 1'b0;
    endtask

    typedef struct {
        logic        s;
        logic [1:0]  m;
        logic [31:0] a, b;
        logic [31:0] lo, hi;
        logic [1:0]  nz;
        logic        er;
        int          lat, busy;
    } vec_t;

    vec_t vt[9];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, bcyc, cnt;
        logic [31:0] lo, hi, e_lo, e_hi;
        logic [1:0]  nz, e_nz;
        logic        er, e_er, got, s;
        logic [1:0]  m;
        logic [31:0] a, b;

        vt[0] = '{1'b0, 2'b00, 32'd7, 32'd6, 32'd42, 32'd0, 2'b00, 1'b0, 35, 34};
        vt[1] = '{1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 2'b10, 1'b0, 35, 34};
        vt[2] = '{1'b0, 2'b10, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 1'b0, 35, 34};
        vt[3] = '{1'b0, 2'b10, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 2'b00, 1'b0, 35, 34};
        vt[4] = '{1'b0, 2'b00, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000000, 2'b01, 1'b0, 35, 34};
        vt[5] = '{1'b0, 2'b01, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 2'b00, 1'b0, 35, 34};
        vt[6] = '{1'b1, 2'b01, 32'h12345678, 32'h9ABCDEF0, 32'h242D2080, 32'h0B00EA4E, 2'b00, 1'b0, 11, 10};
        vt[7] = '{1'b0, 2'b11, 32'h00000005, 32'h00000005, 32'h00000000, 32'h00000000, 2'b00, 1'b1, 1, 0};
        vt[8] = '{1'b1, 2'b10, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 1'b0, 11, 10};

        rst = 1'b1; sel = 1'b0; t_start = 1'b0; t_mode = '0; t_a = '0; t_b = '0;
        repeat (2) @(negedge clk);
        t_start = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'({bus1.busy, bus4.busy}), 64'd0);
        chk("rst_done_err", 64'({bus1.done, bus4.done, bus1.err, bus4.err}), 64'd0);
        chk("rst_res1", {bus1.res_hi, bus1.res_lo}, 64'd0);
        chk("rst_res4", {bus4.res_hi, bus4.res_lo}, 64'd0);
        chk("rst_flags", 64'({bus1.flags_nz, bus4.flags_nz}), 64'd0);
        t_start = 1'b0;
        rst = 1'b0;

        foreach (vt[i]) begin
            do_op(vt[i].s, vt[i].m, vt[i].a, vt[i].b, 0, lat, bcyc, lo, hi, nz, er, got);
            chk($sformatf("v%0d_done", i), 64'(got), 64'd1);
            chk($sformatf("v%0d_lo", i), 64'(lo), 64'(vt[i].lo));
            chk($sformatf("v%0d_hi", i), 64'(hi), 64'(vt[i].hi));
            chk($sformatf("v%0d_nz", i), 64'(nz), 64'(vt[i].nz));
            chk($sformatf("v%0d_err", i), 64'(er), 64'(vt[i].er));
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].lat));
            chk($sformatf("v%0d_busy", i), 64'(bcyc), 64'(vt[i].busy));
        end

        // Results stay put after done; a start held only in the done cycle is dropped.
        do_op(1'b0, 2'b01, 32'd3, 32'd5, 0, lat, bcyc, lo, hi, nz, er, got);
        chk("hold_lo", 64'(lo), 64'd15);
        t_start = 1'b1; t_mode = 2'b00; t_a = 32'd9; t_b = 32'd9;
        @(negedge clk);
        t_start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (o_busy || o_done) cnt++;
            @(negedge clk);
        end
        chk("done_cycle_start_ignored", 64'(cnt), 64'd0);
        chk("hold_after_done", {o_hi, o_lo}, 64'd15);

        // Reset during ITER aborts without a done.
        @(negedge clk);
        sel = 1'b0; t_start = 1'b1; t_mode = 2'b01; t_a = 32'h1111; t_b = 32'h2222;
        @(negedge clk);
        t_start = 1'b0;
        repeat (9) @(negedge clk);
        chk("iter10_busy", 64'(o_busy), 64'd1);
        chk("iter10_held_lo", 64'(o_lo), 64'd15);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outputs", {o_hi, o_lo}, 64'd0);
        chk("abort_ctrl", 64'({o_busy, o_done, o_err, o_nz}), 64'd0);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (o_busy || o_done) cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(cnt), 64'd0);
        do_op(1'b0, 2'b00, 32'h1234, 32'h5678, 0, lat, bcyc, lo, hi, nz, er, got);
        chk("after_abort_lo", 64'(lo), 64'h0626_0060);
        chk("after_abort_lat", 64'(lat), 64'd35);

        // Second start mid-ITER must neither restart nor queue.
        model(2'b10, 32'hFFFFFFFB, 32'd7, e_lo, e_hi, e_nz, e_er);
        do_op(1'b0, 2'b10, 32'hFFFFFFFB, 32'd7, 12, lat, bcyc, lo, hi, nz, er, got);
        chk("poke_res", {hi, lo}, {e_hi, e_lo});
        chk("poke_nz", 64'(nz), 64'(e_nz));
        chk("poke_lat", 64'(lat), 64'd35);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_busy || o_done) cnt++;
        end
        chk("poke_not_queued", 64'(cnt), 64'd0);

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            m = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if (i % 5 == 0) a = 32'h80000000;
            if (i % 7 == 0) b = 32'd0;
            model(m, a, b, e_lo, e_hi, e_nz, e_er);
            do_op(s, m, a, b, 0, lat, bcyc, lo, hi, nz, er, got);
            chk($sformatf("r%0d_res", i), {hi, lo}, {e_hi, e_lo});
            chk($sformatf("r%0d_nz", i), 64'(nz), 64'(e_nz));
            chk($sformatf("r%0d_err", i), 64'(er), 64'(e_er));
            chk($sformatf("r%0d_lat", i), 64'(lat), e_er ? 64'd1 : (s ? 64'd11 : 64'd35));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_seq_unit.md
Name: mul_seq_unit

Overview:
- Parametrised multicycle integer multiplier for the multicycle ARM datapath; successor to the single-cycle MUL/UMULL/SMULL ALU path.
- Controller asserts start with operands and mode, holds the main FSM in a wait state while busy, then writes res_lo (and res_hi for long multiplies) on done.
- Width and bits retired per cycle are parametrised, so the same block serves 32-bit and wider cores and trades area against latency.

Parameters:
- WIDTH, 32, operand width; long results are 2*WIDTH.
- BPC, 1, multiplier bits retired per iteration cycle; must divide WIDTH. Legal values are 1, 2 and 4.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  2  00 MUL, 01 UMULL, 10 SMULL, 11 illegal.
- op_a  input  WIDTH  multiplicand (Rn/Rm per decode).
- op_b  input  WIDTH  multiplier.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; results are valid and held until the next accepted start.
- res_lo  output  WIDTH  low half of the product.
- res_hi  output  WIDTH  high half; forced to 0 for MUL.
- flags_nz  output  2  {N,Z} of the architected result; C and V are not produced.
- err  output  1  pulses with done for an illegal mode.

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE.
  - busy, done, err, res_lo, res_hi and flags_nz all 0.
  - Reset in any state aborts the operation. Outputs read 0 in the cycle after the reset edge.
- States: IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
- IDLE:
  - On start=1, latch op_a, op_b and mode, then go to PREP.
  - For mode 11, go directly to DONE with err=1 and results 0.
- PREP (1 cycle):
  - SMULL: replace each operand with its absolute value; record sign = a_msb XOR b_msb.
  - Other modes: sign=0.
  - Clear the 2*WIDTH accumulator. Load iteration counter = WIDTH/BPC - 1.
- ITER (WIDTH/BPC cycles):
  - Each cycle, add (multiplicand * low BPC bits of the multiplier) into the upper accumulator half.
  - Shift the accumulator and multiplier right by BPC. Decrement the counter.
  - Leave after the cycle in which counter==0.
- Unsigned arithmetic rules:
  - Accumulator carry-out is kept, so the accumulator needs WIDTH+BPC bits of headroom internally.
  - abs(most-negative) = 2^(WIDTH-1), which is correct when treated as unsigned.
- FIX (1 cycle):
  - If sign=1, two's-complement negate the full 2*WIDTH accumulator.
  - Register res_lo and res_hi; res_hi=0 when mode=MUL.
  - Compute flags:
    - MUL: N = res_lo[WIDTH-1], Z = (res_lo==0).
    - Long multiplies: N = res_hi[WIDTH-1], Z = (full 2*WIDTH result == 0).
- DONE (1 cycle): done=1, busy=0. Results are stable from this cycle onward.
- Latency: start at edge 0 gives done high during cycle WIDTH/BPC + 3. Defaults give 35 cycles; BPC=4 gives 11 cycles.
- busy is 1 exactly in PREP, ITER and FIX.
- start while not IDLE is ignored and does not queue.
- start in the same cycle as done is ignored; earliest accept is the cycle after done.
- Operand or mode changes after acceptance have no effect.
- reset and start asserted together: reset wins.

Decomposition:
- Shared package mul_seq_pkg holds:
  - Mode encodings: MODE_MUL, MODE_UMULL, MODE_SMULL, MODE_ILLEGAL.
  - State encoding: ST_IDLE, ST_PREP, ST_ITER, ST_FIX, ST_DONE.
  - Function for the iteration count (WIDTH/BPC).
- One combinational sub-module, mul_step: given the accumulator high part, the multiplicand and BPC multiplier bits, it returns the next accumulator high part plus carry. It is instantiated once per ITER cycle path.

Test Plan:
- Defaults, MUL 7*6 -> done in cycle 35; res_lo=42, res_hi=0, flags_nz=00, err=0. busy high for exactly 34 cycles.
- UMULL 0xFFFFFFFF*0xFFFFFFFF -> res_hi=0xFFFFFFFE, res_lo=0x00000001, flags_nz=10.
- SMULL 0xFFFFFFFF*0x00000001 -> res_hi=res_lo=0xFFFFFFFF, N=1. SMULL 0x80000000*0x80000000 -> res_hi=0x40000000, res_lo=0, flags 00.
- MUL 0x00010000*0x00010000 -> res_lo=0, res_hi=0, flags_nz=01. UMULL of the same operands -> res_hi=1, res_lo=0, Z=0.
- Protocol cases:
  - Second start pulsed mid-ITER is ignored; the result matches the first request.
  - reset asserted in ITER cycle 10 -> outputs all 0 next cycle, no done. A fresh start then completes normally.
- Parameter and illegal-mode cases:
  - BPC=4, UMULL 0x12345678*0x9ABCDEF0 -> done in cycle 11; res_hi=0x0B00EA4E, res_lo=0x242D2080.
  - mode=11 -> done and err high in the cycle after start, results 0, busy never asserted.
